// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared types and constants for the core memory-access stage.
//   mau_state_t  : access FSM state (IDLE / WAIT)
//   mau_req_t    : execute-stage micro-op bundle {we, addr, wd, tag}
//   CACHE_ADDR_W : word-address width decoded by the cache
//   MAU_TAG_W    : destination-register tag width carried with a micro-op
//   addr_fault() : 1 when any address bit at or above the decode limit is set
// -----------------------------------------------------------------------------
package mem_access_pkg;

    localparam int CACHE_ADDR_W = 27;
    localparam int MAU_TAG_W    = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mau_state_t;

    typedef struct packed {
        logic                 we;
        logic [31:0]          addr;
        logic [31:0]          wd;
        logic [MAU_TAG_W-1:0] tag;
    } mau_req_t;

    function automatic logic addr_fault(input logic [31:0] addr, input int limit_bits);
        return (addr >> limit_bits) != 32'd0;
    endfunction

endpackage

// File: rtl/sat_counter32.sv
// -----------------------------------------------------------------------------
// sat_counter32
// 32-bit up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   i_clock : clock
//   i_clear : synchronous clear, active high, wins over i_en
//   i_en    : count enable
//   o_count : current count
// -----------------------------------------------------------------------------
module sat_counter32 (
    input  logic        i_clock,
    input  logic        i_clear,
    input  logic        i_en,
    output logic [31:0] o_count
);

    logic [31:0] r_count;

    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != 32'hFFFF_FFFF)) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Memory stage between execute and the cache interconnect. Takes load/store
// micro-ops over valid/ready, issues a one-cycle strobe to the cache, holds a
// single outstanding access across cache stalls and returns a tagged response
// pulse. Addresses with bits set above the cache decode range are answered
// with a fault response and never reach the cache.
//
// Build option: define MEM_ACCESS_PERF_EN to add saturating performance
// counters (o_perf_stall_cycles, o_perf_accesses).
//
// Ports:
//   i_clock, i_cpu_reset             : clock, synchronous active-high reset
//   i_req_valid/o_req_ready          : micro-op handshake
//   i_req_we/addr/wd/tag             : micro-op payload
//   o_cache_en/we/addr/wd            : cache request, zero when not strobed
//   i_cache_rd, i_cache_stall        : cache read data and busy
//   o_resp_valid/we/rd/tag/fault     : completion pulse and held payload
//   o_perf_stall_cycles/accesses     : only with MEM_ACCESS_PERF_EN
//
// TAG_W must equal mem_access_pkg::MAU_TAG_W (the core's register-tag width).
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no access in flight; accepts a micro-op when the cache is idle
// WAIT  | access issued; waits for the first cycle with cache_stall low
// -----------------------------------------------------------------------------
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int TAG_W           = 5,
    parameter int ADDR_LIMIT_BITS = 27
) (
    input  logic                    i_clock,
    input  logic                    i_cpu_reset,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [31:0]             i_req_addr,
    input  logic [31:0]             i_req_wd,
    input  logic [TAG_W-1:0]        i_req_tag,
    output logic                    o_cache_en,
    output logic                    o_cache_we,
    output logic [CACHE_ADDR_W-1:0] o_cache_addr,
    output logic [31:0]             o_cache_wd,
    input  logic [31:0]             i_cache_rd,
    input  logic                    i_cache_stall,
    output logic                    o_resp_valid,
    output logic                    o_resp_we,
    output logic [31:0]             o_resp_rd,
    output logic [TAG_W-1:0]        o_resp_tag,
`ifdef MEM_ACCESS_PERF_EN
    output logic [31:0]             o_perf_stall_cycles,
    output logic [31:0]             o_perf_accesses,
`endif
    output logic                    o_resp_fault
);

    mau_state_t       r_state;
    mau_state_t       w_state_nxt;
    mau_req_t         w_req;
    logic             w_fault;
    logic             w_accept;
    logic             w_complete;

    logic             r_op_we;
    logic [TAG_W-1:0] r_op_tag;

    logic             r_resp_valid;
    logic             r_resp_we;
    logic [31:0]      r_resp_rd;
    logic [TAG_W-1:0] r_resp_tag;
    logic             r_resp_fault;

    assign w_req   = '{we: i_req_we, addr: i_req_addr, wd: i_req_wd, tag: i_req_tag};
    assign w_fault = addr_fault(w_req.addr, ADDR_LIMIT_BITS);

    // Cache strobe is issued combinationally in the accept cycle so a hit
    // returns data on the very next cycle.
    always_comb begin
        w_state_nxt  = r_state;
        o_req_ready  = 1'b0;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        o_cache_en   = 1'b0;
        o_cache_we   = 1'b0;
        o_cache_addr = '0;
        o_cache_wd   = '0;
        case (r_state)
            IDLE: begin
                // Not ready during reset: a micro-op taken then would be lost.
                o_req_ready = !i_cache_stall && !i_cpu_reset;
                w_accept    = i_req_valid && o_req_ready;
                if (w_accept && !w_fault) begin
                    o_cache_en   = 1'b1;
                    o_cache_we   = w_req.we;
                    o_cache_addr = w_req.addr[CACHE_ADDR_W-1:0];
                    o_cache_wd   = w_req.wd;
                    w_state_nxt  = WAIT;
                end
            end
            WAIT: begin
                if (!i_cache_stall) begin
                    w_complete  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_cpu_reset) begin
            r_state      <= IDLE;
            r_op_we      <= 1'b0;
            r_op_tag     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_we    <= 1'b0;
            r_resp_rd    <= '0;
            r_resp_tag   <= '0;
            r_resp_fault <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_resp_valid <= 1'b0;
            if (w_accept) begin
                r_op_we  <= w_req.we;
                r_op_tag <= w_req.tag;
            end
            // Accept and completion are mutually exclusive (accept needs IDLE).
            if (w_accept && w_fault) begin
                r_resp_valid <= 1'b1;
                r_resp_fault <= 1'b1;
                r_resp_we    <= w_req.we;
                r_resp_tag   <= w_req.tag;
                r_resp_rd    <= '0;
            end else if (w_complete) begin
                r_resp_valid <= 1'b1;
                r_resp_fault <= 1'b0;
                r_resp_we    <= r_op_we;
                r_resp_tag   <= r_op_tag;
                r_resp_rd    <= r_op_we ? 32'd0 : i_cache_rd;
            end
        end
    end

    assign o_resp_valid = r_resp_valid;
    assign o_resp_we    = r_resp_we;
    assign o_resp_rd    = r_resp_rd;
    assign o_resp_tag   = r_resp_tag;
    assign o_resp_fault = r_resp_fault;

`ifdef MEM_ACCESS_PERF_EN
    logic w_stall_tick;

    assign w_stall_tick = (r_state == WAIT) && i_cache_stall;

    sat_counter32 u_perf_stall (
        .i_clock (i_clock),
        .i_clear (i_cpu_reset),
        .i_en    (w_stall_tick),
        .o_count (o_perf_stall_cycles)
    );

    sat_counter32 u_perf_access (
        .i_clock (i_clock),
        .i_clear (i_cpu_reset),
        .i_en    (o_cache_en),
        .o_count (o_perf_accesses)
    );
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int TAG_W = 5;

    logic             clock = 1'b0;
    logic             cpu_reset;
    logic             req_valid;
    logic             req_we;
    logic [31:0]      req_addr;
    logic [31:0]      req_wd;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      cache_rd;
    logic             cache_stall;

    logic             req_ready;
    logic             cache_en;
    logic             cache_we;
    logic [26:0]      cache_addr;
    logic [31:0]      cache_wd;
    logic             resp_valid;
    logic             resp_we;
    logic [31:0]      resp_rd;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_fault;
`ifdef MEM_ACCESS_PERF_EN
    logic [31:0]      perf_stall_cycles;
    logic [31:0]      perf_accesses;
`endif

    always #5 clock = ~clock;

    mem_access_unit #(.TAG_W(TAG_W), .ADDR_LIMIT_BITS(27)) dut (
        .i_clock            (clock),
        .i_cpu_reset        (cpu_reset),
        .i_req_valid        (req_valid),
        .o_req_ready        (req_ready),
        .i_req_we           (req_we),
        .i_req_addr         (req_addr),
        .i_req_wd           (req_wd),
        .i_req_tag          (req_tag),
        .o_cache_en         (cache_en),
        .o_cache_we         (cache_we),
        .o_cache_addr       (cache_addr),
        .o_cache_wd         (cache_wd),
        .i_cache_rd         (cache_rd),
        .i_cache_stall      (cache_stall),
        .o_resp_valid       (resp_valid),
        .o_resp_we          (resp_we),
        .o_resp_rd          (resp_rd),
        .o_resp_tag         (resp_tag),
`ifdef MEM_ACCESS_PERF_EN
        .o_perf_stall_cycles(perf_stall_cycles),
        .o_perf_accesses    (perf_accesses),
`endif
        .o_resp_fault       (resp_fault)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one in-flight op plus the last response presented.
    logic             m_busy = 1'b0;
    logic             m_we = 1'b0;
    logic [TAG_W-1:0] m_tag = '0;
    logic             m_rv = 1'b0;
    logic             m_rwe = 1'b0;
    logic             m_rf = 1'b0;
    logic [31:0]      m_rrd = '0;
    logic [TAG_W-1:0] m_rtag = '0;
    logic [31:0]      m_stalls = '0;
    logic [31:0]      m_accs = '0;
    logic             seen_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare at the falling edge, then advance the model
    // to what the rising edge should produce.
    task automatic step();
        logic exp_ready;
        logic acc;
        logic in_rng;
        logic exp_en;
        @(negedge clock);
        exp_ready = !cpu_reset && !m_busy && !cache_stall;
        in_rng    = (req_addr >> 27) == 32'd0;
        acc       = req_valid && exp_ready;
        exp_en    = acc && in_rng;
        seen_en   = cache_en;
        chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
        chk("cache_en", {31'd0, cache_en}, {31'd0, exp_en});
        chk("cache_we", {31'd0, cache_we}, {31'd0, exp_en && req_we});
        chk("cache_addr", {5'd0, cache_addr}, exp_en ? (req_addr & 32'h07FF_FFFF) : 32'd0);
        chk("cache_wd", cache_wd, exp_en ? req_wd : 32'd0);
        chk("resp_valid", {31'd0, resp_valid}, {31'd0, m_rv});
        chk("resp_we", {31'd0, resp_we}, {31'd0, m_rwe});
        chk("resp_rd", resp_rd, m_rrd);
        chk("resp_tag", {27'd0, resp_tag}, {27'd0, m_rtag});
        chk("resp_fault", {31'd0, resp_fault}, {31'd0, m_rf});
`ifdef MEM_ACCESS_PERF_EN
        chk("perf_stall", perf_stall_cycles, m_stalls);
        chk("perf_acc", perf_accesses, m_accs);
`endif
        if (cpu_reset) begin
            m_busy = 0; m_we = 0; m_tag = '0;
            m_rv = 0; m_rwe = 0; m_rf = 0; m_rrd = '0; m_rtag = '0;
            m_stalls = '0; m_accs = '0;
        end else begin
            if (m_busy && cache_stall && m_stalls != 32'hFFFF_FFFF) m_stalls++;
            if (exp_en && m_accs != 32'hFFFF_FFFF) m_accs++;
            m_rv = 0;
            if (m_busy && !cache_stall) begin
                m_rv = 1; m_rwe = m_we; m_rf = 0; m_rtag = m_tag;
                m_rrd = m_we ? 32'd0 : cache_rd;
                m_busy = 0;
            end else if (acc) begin
                if (in_rng) begin
                    m_busy = 1; m_we = req_we; m_tag = req_tag;
                end else begin
                    m_rv = 1; m_rf = 1; m_rwe = req_we; m_rtag = req_tag; m_rrd = 32'd0;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    // Called right after the accepting step; k is the response cycle offset
    // from the accept cycle. The first n_stall cycles after accept stall.
    task automatic wait_resp(input int n_stall, output int k);
        k = 1;
        while (resp_valid !== 1'b1 && k < 60) begin
            cache_stall = (k <= n_stall);
            step();
            k++;
        end
        cache_stall = 1'b0;
    endtask

    initial begin
        int k;
        int j;
        int acc_cyc[4];
        int npulse;
        logic [TAG_W-1:0] got[$];

        cpu_reset = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wd = 0;
        req_tag = 0; cache_rd = 0; cache_stall = 0;
        repeat (2) begin @(posedge clock); #1; end
        step();
        cpu_reset = 0;
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rd", resp_rd, 32'd0);
        step();

        // Load hit
        req_valid = 1; req_we = 0; req_addr = 32'h100; req_tag = 5'd3;
        cache_rd = 32'hDEAD_BEEF;
        step();
        chk("hit_accept", {31'd0, seen_en}, 32'd1);
        req_valid = 0;
        wait_resp(0, k);
        chk("hit_latency", k, 2);
        chk("hit_rd", resp_rd, 32'hDEAD_BEEF);
        chk("hit_tag", {27'd0, resp_tag}, 32'd3);
        chk("hit_fault", {31'd0, resp_fault}, 32'd0);
        step();

        // Store miss, 10 stall cycles
        req_valid = 1; req_we = 1; req_addr = 32'h07FF_FFFF; req_wd = 32'h1234_5678;
        req_tag = 5'd4; cache_rd = 32'hCAFE_F00D;
        step();
        chk("miss_accept", {31'd0, seen_en}, 32'd1);
        req_valid = 0;
        wait_resp(10, k);
        chk("miss_latency", k, 12);
        chk("miss_we", {31'd0, resp_we}, 32'd1);
        chk("miss_rd", resp_rd, 32'd0);
        step();

        // Fault
        req_valid = 1; req_we = 0; req_addr = 32'h0800_0000; req_tag = 5'd7;
        step();
        chk("fault_no_en", {31'd0, seen_en}, 32'd0);
        req_valid = 0;
        wait_resp(0, k);
        chk("fault_latency", k, 1);
        chk("fault_flag", {31'd0, resp_fault}, 32'd1);
        chk("fault_rd", resp_rd, 32'd0);
        chk("fault_tag", {27'd0, resp_tag}, 32'd7);
        step();

        // Busy cache while IDLE
        req_valid = 1; req_we = 0; req_addr = 32'h40; req_tag = 5'd9;
        cache_stall = 1;
        repeat (3) begin
            step();
            chk("busy_no_en", {31'd0, seen_en}, 32'd0);
        end
        cache_stall = 0; cache_rd = 32'h0BAD_CAFE;
        step();
        chk("busy_accept", {31'd0, seen_en}, 32'd1);
        req_valid = 0;
        wait_resp(0, k);
        chk("busy_latency", k, 2);
        chk("busy_rd", resp_rd, 32'h0BAD_CAFE);
        step();

        // Back-to-back hits
        j = 0;
        for (int c = 0; c < 12; c++) begin
            req_valid = (j < 4); req_we = 0;
            req_tag = 5'(10 + j); req_addr = 32'h200 + 32'(j);
            cache_rd = 32'hA000_0000 + 32'(c);
            step();
            if (seen_en && j < 4) begin
                acc_cyc[j] = c;
                j++;
            end
            if (resp_valid) got.push_back(resp_tag);
        end
        req_valid = 0;
        chk("b2b_accepts", j, 4);
        for (int i = 1; i < 4; i++) chk("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 2);
        chk("b2b_resp_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++)
            chk("b2b_tag_order", {27'd0, got[i]}, 32'(10 + i));

        // Reset while stalled in WAIT
        req_valid = 1; req_we = 0; req_addr = 32'h300; req_tag = 5'd21;
        cache_rd = 32'h5555_AAAA;
        step();
        req_valid = 0;
        cache_stall = 1;
        repeat (3) step();
        cpu_reset = 1;
        step();
        cpu_reset = 0;
        chk("rst_wait_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_wait_tag", {27'd0, resp_tag}, 32'd0);
        chk("rst_wait_rd", resp_rd, 32'd0);
        chk("rst_wait_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_wait_en", {31'd0, cache_en}, 32'd0);
`ifdef MEM_ACCESS_PERF_EN
        chk("rst_perf_stall", perf_stall_cycles, 32'd0);
        chk("rst_perf_acc", perf_accesses, 32'd0);
`endif
        step();
        cache_stall = 0;
        npulse = 0;
        repeat (5) begin
            step();
            if (resp_valid) npulse++;
        end
        chk("rst_dropped_op", npulse, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            cache_stall = ($urandom_range(0, 9) < 3);
            req_valid   = 1'($urandom_range(0, 1));
            req_we      = 1'($urandom_range(0, 1));
            req_addr    = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h07FF_FFFF);
            req_wd      = $urandom;
            req_tag     = 5'($urandom);
            cache_rd    = $urandom;
            cpu_reset   = ($urandom_range(0, 99) == 0);
            step();
        end
        cpu_reset = 0; req_valid = 0; cache_stall = 0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Core-side memory stage directly upstream of the cache interconnect.
- Accepts load/store micro-ops from the execute stage via valid/ready and drives the cache master port (en/we/addr/wd).
- Tracks exactly one outstanding access across cache stall cycles and returns load data, tagged with the destination register, to writeback.
- Rejects out-of-range addresses without touching the cache.

Parameters:
- TAG_W, 5, width of the destination-register tag carried with a load
- ADDR_LIMIT_BITS, 27, number of low word-address bits the cache decodes; any set bit above this range is a fault

Ports:
- clock  in  1  core clock; the only clock
- cpu_reset  in  1  synchronous, active-high reset
- req_valid  in  1  execute stage presents a micro-op
- req_ready  out  1  unit can accept a micro-op this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  word address
- req_wd  in  32  store data
- req_tag  in  TAG_W  load destination register
- cache_en  out  1  one-cycle request strobe to cache
- cache_we  out  1  write enable, valid with cache_en
- cache_addr  out  27  word address, valid with cache_en
- cache_wd  out  32  write data, valid with cache_en
- cache_rd  in  32  read data
- cache_stall  in  1  cache busy (its ~idle)
- resp_valid  out  1  one-cycle completion pulse
- resp_we  out  1  completed op was a store
- resp_rd  out  32  load data; 0 for stores and faults
- resp_tag  out  TAG_W  tag of completed op
- resp_fault  out  1  address out of range; op not issued

Behaviour:
- Reset: all outputs 0, state IDLE. Reset wins over any simultaneous event, including mid-access. The cache is reset by the same cpu_reset, so the in-flight access is dropped.
- Cache contract:
  - A request is accepted on a cycle with cache_en=1 and cache_stall=0.
  - Result is valid on the first later cycle with cache_stall=0.
  - cache_en is never asserted while cache_stall=1.
- req_ready = (state==IDLE) && !cache_stall. A micro-op is taken on req_valid && req_ready.
- FSM:
  - IDLE, accepting in-range op: drive cache_en=1 combinationally the same cycle with cache_we/addr/wd from the request; latch we and tag; go to WAIT.
  - IDLE, accepting out-of-range op (req_addr[31:ADDR_LIMIT_BITS] != 0): no cache_en; next cycle resp_valid=1, resp_fault=1, resp_tag = latched tag, resp_rd=0, resp_we=req_we; stay IDLE.
  - WAIT: each cycle with cache_stall=1, stay.
  - WAIT, first cycle with cache_stall=0: register resp_rd = cache_rd (loads) or 0 (stores); resp_valid pulses the next cycle; go to IDLE.
- Latency:
  - Cache hit (stall never high): accept at cycle t, resp_valid at t+2.
  - Miss with N stall cycles: t+2+N.
- Back-to-back: req_ready reasserts in the cycle resp_valid pulses. No request is accepted in the same cycle WAIT completes.
- cache_we/addr/wd are 0 whenever cache_en=0 (no X or stale values).
- resp_* other than resp_valid hold their values until the next completion.

Optional Feature:
- Macro MEM_ACCESS_PERF_EN.
- With it:
  - Adds outputs perf_stall_cycles (32) and perf_accesses (32), both reset to 0.
  - perf_stall_cycles increments on every WAIT cycle with cache_stall=1.
  - perf_accesses increments on every cache_en.
  - Both saturate at 32'hFFFF_FFFF.
- Without it: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_access_pkg holds:
  - typedef enum logic [0:0] {IDLE, WAIT} mau_state_t
  - struct mau_req_t {we, addr, wd, tag}
  - constant CACHE_ADDR_W = 27
- Sub-module sat_counter32 (enable, clear, saturating) is instantiated twice under MEM_ACCESS_PERF_EN.
- No other sub-modules.

Test Plan:
- Load hit:
  - Stimulus: req load addr=0x100, tag=3; cache_stall held 0; cache_rd=0xDEADBEEF.
  - Expected: cache_en at t; resp_valid at t+2 with resp_rd=0xDEADBEEF, resp_tag=3, resp_fault=0.
- Store miss:
  - Stimulus: req store addr=0x7FF_FFFF, wd=0x12345678; cache_stall high 10 cycles after accept.
  - Expected: cache_en/we=1 one cycle; req_ready=0 throughout; resp_valid at t+12 with resp_we=1, resp_rd=0.
- Fault:
  - Stimulus: load addr=0x0800_0000.
  - Expected: cache_en never 1; resp_valid at t+1 with resp_fault=1, resp_rd=0.
- Busy cache:
  - Stimulus: cache_stall=1 while IDLE and req_valid=1.
  - Expected: req_ready=0, cache_en=0; accept occurs on the first cycle stall drops.
- Back-to-back:
  - Stimulus: 4 loads with hits.
  - Expected: accepts at t, t+2, t+4, t+6; responses carry matching tags in order.
- Reset mid-WAIT:
  - Stimulus: cpu_reset pulsed while stalled.
  - Expected: next cycle state IDLE, all outputs 0, no resp_valid for the dropped op.
  - With MEM_ACCESS_PERF_EN: counters read 0.
